// File: rtl/sar_adc_control.sv
// Successive-approximation ADC controller: synchronizes the comparator,
// walks the R2R DAC code MSB to LSB with a fixed settle time per bit,
// and publishes the final code with a one-cycle valid strobe.
module sar_adc_control #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             comp_in,
    output logic [WIDTH-1:0] dac_out,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             valid
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // TRIAL is the first cycle after dac_out changes; SETTLE covers the
    // remaining settle cycles and ends with the bit decision.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRIAL,
        ST_SETTLE
    } state_t;

    state_t           state, nxt_state;
    logic [3:0]       cnt, nxt_cnt;
    logic [IW-1:0]    idx, nxt_idx;
    logic [WIDTH-1:0] nxt_dac, nxt_result;
    logic             nxt_busy, nxt_valid;
    logic [1:0]       sync;
    logic             comp_s;
    logic [WIDTH-1:0] bit_cur, decided;

    assign comp_s  = sync[1];
    // Shifting a single set bit keeps every operation inside WIDTH bits.
    assign bit_cur = ONE << idx;
    assign decided = comp_s ? dac_out : (dac_out & ~bit_cur);

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) sync <= 2'b00;
        else        sync <= {sync[0], comp_in};
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            dac_out <= '0;
            result  <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            idx     <= nxt_idx;
            dac_out <= nxt_dac;
            result  <= nxt_result;
            busy    <= nxt_busy;
            valid   <= nxt_valid;
        end
    end

    // Next-state and output logic; start is only looked at in IDLE.
    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        nxt_idx    = idx;
        nxt_dac    = dac_out;
        nxt_result = result;
        nxt_busy   = busy;
        nxt_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                nxt_dac = result;
                if (start) begin
                    nxt_state = ST_TRIAL;
                    nxt_idx   = IW'(WIDTH - 1);
                    nxt_dac   = ONE << (WIDTH - 1);
                    nxt_busy  = 1'b1;
                    nxt_cnt   = '0;
                end
            end
            ST_TRIAL: begin
                nxt_state = ST_SETTLE;
                nxt_cnt   = 4'd1;
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_CNT) begin
                    nxt_cnt = '0;
                    if (idx == '0) begin
                        nxt_state  = ST_IDLE;
                        nxt_dac    = decided;
                        nxt_result = decided;
                        nxt_valid  = 1'b1;
                        nxt_busy   = 1'b0;
                    end else begin
                        nxt_state = ST_TRIAL;
                        nxt_dac   = decided | (bit_cur >> 1);
                        nxt_idx   = idx - 1'b1;
                    end
                end else begin
                    nxt_cnt = cnt + 4'd1;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_busy  = 1'b0;
            end
        endcase
    end

endmodule
